// File: rtl/buffer2axis.sv
// buffer2axis: serialises a captured cell grid into an AXI-Stream frame of
// pixel words, one beat per cell in row-major order, TLAST on the final cell.
module buffer2axis #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH-1:0]         alive_color,
  input  logic [DWIDTH-1:0]         dead_color,
  input  logic [WIDTH*HEIGHT-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic                      frame_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      grid;
  logic [DWIDTH-1:0] alive_q;
  logic [DWIDTH-1:0] dead_q;
  logic              capture;
  logic              last_beat;

  assign capture   = in_valid && in_ready;
  assign last_beat = (cnt == LAST_IDX);

  // Handshake and stream outputs are decoded from state so reset clears them at once
  always_comb begin
    in_ready      = (state == IDLE) && !rst;
    M_AXIS_TVALID = (state == SEND);
    M_AXIS_TLAST  = (state == SEND) && last_beat;
    M_AXIS_TDATA  = '0;
    if (state == SEND) begin
      M_AXIS_TDATA = grid[cnt] ? alive_q : dead_q;
    end
  end

  // Control: Idle/Send sequencing, beat counter and end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (capture) begin
          state <= SEND;
          cnt   <= '0;
        end
      end else if (M_AXIS_TREADY) begin
        if (last_beat) begin
          cnt        <= '0;
          state      <= IDLE;
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Frame payload snapshot, taken only on the capture edge and not reset
  always_ff @(posedge clk) begin
    if (capture) begin
      grid    <= in_data;
      alive_q <= alive_color;
      dead_q  <= dead_color;
    end
  end

endmodule

// File: tb/tb_buffer2axis.sv
// Self-checking bench for buffer2axis: a 2x2 instance for the frame and
// handshake scenarios, a 1x1 instance and a default 32x32 instance.
`timescale 1ns/1ps
module tb_buffer2axis;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // 2x2 instance
  logic [31:0] a_alive, a_dead, a_tdata;
  logic [3:0]  a_in_data;
  logic        a_in_valid, a_in_ready, a_tvalid, a_tready, a_tlast, a_done;

  // 1x1 instance
  logic [7:0]  b_alive, b_dead, b_tdata;
  logic [0:0]  b_in_data;
  logic        b_in_valid, b_in_ready, b_tvalid, b_tready, b_tlast, b_done;

  // 32x32 instance
  logic [31:0]   c_alive, c_dead, c_tdata;
  logic [1023:0] c_in_data;
  logic          c_in_valid, c_in_ready, c_tvalid, c_tready, c_tlast, c_done;

  buffer2axis #(.DWIDTH(32), .WIDTH(2), .HEIGHT(2)) dut_a (
    .clk(clk), .rst(rst), .alive_color(a_alive), .dead_color(a_dead),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .M_AXIS_TDATA(a_tdata), .M_AXIS_TVALID(a_tvalid), .M_AXIS_TREADY(a_tready),
    .M_AXIS_TLAST(a_tlast), .frame_done(a_done)
  );

  buffer2axis #(.DWIDTH(8), .WIDTH(1), .HEIGHT(1)) dut_b (
    .clk(clk), .rst(rst), .alive_color(b_alive), .dead_color(b_dead),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .M_AXIS_TDATA(b_tdata), .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(b_tready),
    .M_AXIS_TLAST(b_tlast), .frame_done(b_done)
  );

  buffer2axis dut_c (
    .clk(clk), .rst(rst), .alive_color(c_alive), .dead_color(c_dead),
    .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .M_AXIS_TDATA(c_tdata), .M_AXIS_TVALID(c_tvalid), .M_AXIS_TREADY(c_tready),
    .M_AXIS_TLAST(c_tlast), .frame_done(c_done)
  );

  // Reference frame: one beat per cell, row-major, colour chosen by the cell bit
  logic [31:0] exp_d[$];
  function automatic void model_frame(input logic [3:0] g, input logic [31:0] al,
                                      input logic [31:0] de);
    exp_d.delete();
    for (int i = 0; i < 4; i++) exp_d.push_back(g[i] ? al : de);
  endfunction

  // Observed frame from the 2x2 instance
  logic [31:0] got_d[$];
  logic        got_l[$];
  // {timeout, lead gap, valid dropped, stall unstable, early done,
  //  done after last, done one later, in_ready after last, tvalid one later}
  logic [8:0]  fstat;
  localparam logic [8:0] ST_IDLE_AFTER = 9'b0_0000_1_0_1_0;
  localparam logic [8:0] ST_RECAPTURE  = 9'b0_0000_1_0_1_1;

  // Drives TREADY (0: always 1, 1: pattern 1,0,0 repeating, 2: random) and
  // records accepted beats; called and returns at a falling edge.
  task automatic collect_a(input int mode);
    logic [31:0] pd;
    logic        pl;
    bit          stalled, fin;
    int          c, lead, drop, unst, early;
    stalled = 0; fin = 0; c = 0; lead = 0; drop = 0; unst = 0; early = 0;
    pd = '0; pl = 1'b0;
    got_d.delete(); got_l.delete();
    while (!fin && c < 200) begin
      case (mode)
        0:       a_tready = 1'b1;
        1:       a_tready = (c % 3 == 0);
        default: a_tready = 1'($urandom_range(0, 1));
      endcase
      if (stalled && (a_tvalid !== 1'b1 || a_tdata !== pd || a_tlast !== pl)) unst++;
      if (a_tvalid !== 1'b1) begin
        if (got_d.size() == 0) lead++; else drop++;
      end
      if (a_done !== 1'b0) early++;
      if (a_tvalid === 1'b1 && a_tready) begin
        got_d.push_back(a_tdata);
        got_l.push_back(a_tlast);
        stalled = 0;
        if (a_tlast === 1'b1) fin = 1;
      end else if (a_tvalid === 1'b1) begin
        stalled = 1; pd = a_tdata; pl = a_tlast;
      end
      c++;
      @(negedge clk);
    end
    fstat[8] = !fin;
    fstat[7] = (lead != 0);
    fstat[6] = (drop != 0);
    fstat[5] = (unst != 0);
    fstat[4] = (early != 0);
    fstat[3] = a_done;
    fstat[1] = a_in_ready;
    @(negedge clk);
    fstat[2] = a_done;
    fstat[0] = a_tvalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({a_in_ready, a_tvalid, a_tlast, a_done, |a_tdata,
         b_in_ready, b_tvalid, b_tlast, b_done, |b_tdata,
         c_in_ready, c_tvalid, c_tlast, c_done, |c_tdata} !== 15'b0)
      $display("FAIL reset_state a=%b%b%b%b%h b=%b%b%b%b%h c=%b%b%b%b%h required all zero",
               a_in_ready, a_tvalid, a_tlast, a_done, a_tdata,
               b_in_ready, b_tvalid, b_tlast, b_done, b_tdata,
               c_in_ready, c_tvalid, c_tlast, c_done, c_tdata);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111)
      $display("FAIL reset_release in_ready=%b%b%b required 111", a_in_ready, b_in_ready, c_in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    a_in_data = 4'b1010; a_alive = 32'hFFFF_FFFF; a_dead = 32'h0; a_tready = 1'b1;
    a_in_valid = 1'b1;
    total_cnt++;
    if (a_in_ready !== 1'b1) $display("FAIL basic_ready_idle got=%b required 1", a_in_ready);
    else pass_cnt++;
    @(negedge clk);
    a_in_valid = 1'b0;
    total_cnt++;
    if ({a_tvalid, a_in_ready} !== 2'b10)
      $display("FAIL basic_latency tvalid,in_ready=%b%b required 10", a_tvalid, a_in_ready);
    else pass_cnt++;
    model_frame(4'b1010, 32'hFFFF_FFFF, 32'h0);
    collect_a(0);
    total_cnt++;
    if (got_d.size() !== exp_d.size())
      $display("FAIL basic_len got=%0d required %0d", got_d.size(), exp_d.size());
    else pass_cnt++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      total_cnt++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1))
        $display("FAIL basic_beat%0d data=%h last=%b required data=%h last=%b",
                 i, got_d[i], got_l[i], exp_d[i], (i == exp_d.size() - 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (fstat !== ST_IDLE_AFTER) $display("FAIL basic_status got=%b required %b", fstat, ST_IDLE_AFTER);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [3:0]  g;
    logic [31:0] al, de;
    g = 4'($urandom); al = $urandom; de = $urandom;
    a_in_data = g; a_alive = al; a_dead = de; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = ~g; a_alive = ~al; a_dead = ~de;
    model_frame(g, al, de);
    collect_a(0);
    total_cnt++;
    if (got_d.size() !== exp_d.size())
      $display("FAIL hold_len got=%0d required %0d", got_d.size(), exp_d.size());
    else pass_cnt++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      total_cnt++;
      if (got_d[i] !== exp_d[i]) $display("FAIL hold_beat%0d data=%h required %h", i, got_d[i], exp_d[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (fstat !== ST_IDLE_AFTER) $display("FAIL hold_status got=%b required %b", fstat, ST_IDLE_AFTER);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] g;
    for (int k = 0; k < 6; k++) begin
      g = 4'($urandom); a_alive = $urandom; a_dead = $urandom;
      a_in_data = g; a_in_valid = 1'b1;
      model_frame(g, a_alive, a_dead);
      @(negedge clk);
      a_in_valid = 1'b0;
      collect_a((k < 3) ? 1 : 2);
      total_cnt++;
      if (got_d.size() !== exp_d.size())
        $display("FAIL bp%0d_len got=%0d required %0d", k, got_d.size(), exp_d.size());
      else pass_cnt++;
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        total_cnt++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1))
          $display("FAIL bp%0d_beat%0d data=%h last=%b required data=%h last=%b",
                   k, i, got_d[i], got_l[i], exp_d[i], (i == exp_d.size() - 1));
        else pass_cnt++;
      end
      total_cnt++;
      if (fstat !== ST_IDLE_AFTER) $display("FAIL bp%0d_status got=%b required %b", k, fstat, ST_IDLE_AFTER);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  g1, g2;
    logic [31:0] al, de;
    g1 = 4'($urandom); g2 = ~g1; al = $urandom; de = ~al;
    a_alive = al; a_dead = de; a_in_data = g1; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_data = g2;
    model_frame(g1, al, de);
    collect_a(0);
    total_cnt++;
    if (got_d.size() !== exp_d.size())
      $display("FAIL b2b_f1_len got=%0d required %0d", got_d.size(), exp_d.size());
    else pass_cnt++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      total_cnt++;
      if (got_d[i] !== exp_d[i]) $display("FAIL b2b_f1_beat%0d data=%h required %h", i, got_d[i], exp_d[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (fstat !== ST_RECAPTURE) $display("FAIL b2b_f1_status got=%b required %b", fstat, ST_RECAPTURE);
    else pass_cnt++;
    a_in_valid = 1'b0;
    model_frame(g2, al, de);
    collect_a(0);
    total_cnt++;
    if (got_d.size() !== exp_d.size())
      $display("FAIL b2b_f2_len got=%0d required %0d", got_d.size(), exp_d.size());
    else pass_cnt++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      total_cnt++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == exp_d.size() - 1))
        $display("FAIL b2b_f2_beat%0d data=%h last=%b required data=%h", i, got_d[i], got_l[i], exp_d[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (fstat !== ST_IDLE_AFTER) $display("FAIL b2b_f2_status got=%b required %b", fstat, ST_IDLE_AFTER);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    logic       saw_last;
    saw_last = 1'b0;
    g = 4'($urandom); a_alive = $urandom; a_dead = $urandom; a_tready = 1'b1;
    a_in_data = g; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    saw_last = saw_last | a_tlast;
    @(negedge clk);
    saw_last = saw_last | a_tlast;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({a_tvalid, a_tlast, a_in_ready, a_done, |a_tdata, saw_last} !== 6'b0)
      $display("FAIL rstmid_async tvalid=%b tlast=%b in_ready=%b done=%b tdata=%h early_last=%b required all zero",
               a_tvalid, a_tlast, a_in_ready, a_done, a_tdata, saw_last);
    else pass_cnt++;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({a_in_ready, a_done, a_tvalid, a_tlast} !== 4'b1000)
      $display("FAIL rstmid_after in_ready,done,tvalid,tlast=%b%b%b%b required 1000",
               a_in_ready, a_done, a_tvalid, a_tlast);
    else pass_cnt++;
    g = 4'($urandom);
    a_in_data = g; a_in_valid = 1'b1;
    model_frame(g, a_alive, a_dead);
    @(negedge clk);
    a_in_valid = 1'b0;
    collect_a(0);
    total_cnt++;
    if (got_d.size() !== exp_d.size())
      $display("FAIL rstmid_len got=%0d required %0d", got_d.size(), exp_d.size());
    else pass_cnt++;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      total_cnt++;
      if (got_d[i] !== exp_d[i]) $display("FAIL rstmid_beat%0d data=%h required %h", i, got_d[i], exp_d[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (fstat !== ST_IDLE_AFTER) $display("FAIL rstmid_status got=%b required %b", fstat, ST_IDLE_AFTER);
    else pass_cnt++;
  endtask

  task automatic test_single_cell();
    logic [7:0] al, de, ex;
    for (int k = 0; k < 2; k++) begin
      al = 8'($urandom); de = ~al; ex = (k == 0) ? al : de;
      b_alive = al; b_dead = de; b_in_data = (k == 0) ? 1'b1 : 1'b0;
      b_tready = 1'b1; b_in_valid = 1'b1;
      total_cnt++;
      if (b_in_ready !== 1'b1) $display("FAIL single%0d_ready got=%b required 1", k, b_in_ready);
      else pass_cnt++;
      @(negedge clk);
      b_in_valid = 1'b0;
      total_cnt++;
      if ({b_tvalid, b_tlast, b_tdata} !== {2'b11, ex})
        $display("FAIL single%0d_beat tvalid=%b tlast=%b tdata=%h required 1 1 %h", k, b_tvalid, b_tlast, b_tdata, ex);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({b_done, b_in_ready, b_tvalid} !== 3'b110)
        $display("FAIL single%0d_done done,in_ready,tvalid=%b%b%b required 110", k, b_done, b_in_ready, b_tvalid);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_full_grid();
    int beats, bad, nlast, last_idx;
    bit fin, done_ok;
    logic [31:0] al;
    beats = 0; bad = 0; nlast = 0; last_idx = -1; fin = 0;
    al = $urandom;
    c_alive = al; c_dead = ~al; c_in_data = '1; c_tready = 1'b1; c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0;
    for (int c = 0; c < 1100 && !fin; c++) begin
      if (c_tvalid === 1'b1) begin
        if (c_tdata !== al) bad++;
        if (c_tlast === 1'b1) begin nlast++; last_idx = beats; fin = 1; end
        beats++;
      end
      @(negedge clk);
    end
    done_ok = (c_done === 1'b1);
    total_cnt++;
    if (beats != 1024 || bad != 0 || nlast != 1 || last_idx != 1023 || !done_ok)
      $display("FAIL full_grid beats=%0d bad=%0d tlasts=%0d last_idx=%0d done=%b required 1024 0 1 1023 1",
               beats, bad, nlast, last_idx, done_ok);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_alive = '0; a_dead = '0; a_in_data = '0; a_in_valid = 1'b0; a_tready = 1'b0;
    b_alive = '0; b_dead = '0; b_in_data = '0; b_in_valid = 1'b0; b_tready = 1'b0;
    c_alive = '0; c_dead = '0; c_in_data = '0; c_in_valid = 1'b0; c_tready = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_single_cell();
    test_full_grid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
